// File: rtl/dec_ex_pipe.sv
// Decode-to-Execute pipeline register: a two-entry buffer (OUT + SKID) with a registered ReadyD.
// Optional performance counters are enabled with the DEC_EX_PIPE_PERF_EN macro.
module dec_ex_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_AW     = 5,
    parameter int CTRL_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ValidD,
    output logic                  ReadyD,
    input  logic [DATA_WIDTH-1:0] RD1D,
    input  logic [DATA_WIDTH-1:0] RD2D,
    input  logic [DATA_WIDTH-1:0] PCD,
    input  logic [DATA_WIDTH-1:0] PCPlus4D,
    input  logic [DATA_WIDTH-1:0] ExtImmD,
    input  logic [REG_AW-1:0]     Rs1D,
    input  logic [REG_AW-1:0]     Rs2D,
    input  logic [REG_AW-1:0]     RdD,
    input  logic [6:0]            opcodeD,
    input  logic [2:0]            funct3D,
    input  logic [CTRL_WIDTH-1:0] CtrlD,
    input  logic                  FlushE,
    input  logic                  ReadyE,
    output logic                  ValidE,
    output logic [DATA_WIDTH-1:0] RD1E,
    output logic [DATA_WIDTH-1:0] RD2E,
    output logic [DATA_WIDTH-1:0] PCE,
    output logic [DATA_WIDTH-1:0] PCPlus4E,
    output logic [DATA_WIDTH-1:0] ExtImmE,
    output logic [REG_AW-1:0]     Rs1E,
    output logic [REG_AW-1:0]     Rs2E,
    output logic [REG_AW-1:0]     RdE,
    output logic [6:0]            opcodeE,
    output logic [2:0]            funct3E,
    output logic [CTRL_WIDTH-1:0] CtrlE,
    output logic [31:0]           StallCnt,
    output logic [31:0]           BubbleCnt
);

    localparam int PW = 5*DATA_WIDTH + 3*REG_AW + 7 + 3 + CTRL_WIDTH;

    logic [PW-1:0] in_pl_s;
    logic [PW-1:0] out_pl_q, out_pl_d;
    logic [PW-1:0] skid_pl_q, skid_pl_d;
    logic          out_v_q, out_v_d;
    logic          skid_v_q, skid_v_d;
    logic          ready_q;
    logic          accept_s, consume_s, out_free_s;

    assign in_pl_s = {RD1D, RD2D, PCD, PCPlus4D, ExtImmD, Rs1D, Rs2D, RdD, opcodeD, funct3D, CtrlD};

    assign accept_s   = ValidD & ready_q;
    assign consume_s  = out_v_q & ReadyE;
    assign out_free_s = ~out_v_q | consume_s;

    // Next-state for both entries; the OUT payload is forced to zero whenever OUT is empty.
    always_comb begin
        out_v_d   = out_v_q;
        out_pl_d  = out_pl_q;
        skid_v_d  = skid_v_q;
        skid_pl_d = skid_pl_q;
        if (FlushE) begin
            out_v_d  = 1'b0;
            out_pl_d = '0;
            skid_v_d = 1'b0;
        end else if (out_free_s) begin
            if (skid_v_q) begin
                out_v_d  = 1'b1;
                out_pl_d = skid_pl_q;
                skid_v_d = accept_s;
                if (accept_s) begin
                    skid_pl_d = in_pl_s;
                end else begin
                    skid_pl_d = skid_pl_q;
                end
            end else begin
                out_v_d  = accept_s;
                skid_v_d = 1'b0;
                if (accept_s) begin
                    out_pl_d = in_pl_s;
                end else begin
                    out_pl_d = '0;
                end
            end
        end else if (accept_s) begin
            // OUT is stalled; accept is only possible when SKID is empty, so nothing is overwritten.
            skid_v_d  = 1'b1;
            skid_pl_d = in_pl_s;
        end else begin
            skid_v_d = skid_v_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_v_q   <= 1'b0;
            out_pl_q  <= '0;
            skid_v_q  <= 1'b0;
            skid_pl_q <= '0;
            ready_q   <= 1'b1;
        end else begin
            out_v_q   <= out_v_d;
            out_pl_q  <= out_pl_d;
            skid_v_q  <= skid_v_d;
            skid_pl_q <= skid_pl_d;
            ready_q   <= ~skid_v_d;
        end
    end

    assign ReadyD = ready_q;
    assign ValidE = out_v_q;
    assign {RD1E, RD2E, PCE, PCPlus4E, ExtImmE, Rs1E, Rs2E, RdE, opcodeE, funct3E, CtrlE} = out_pl_q;

`ifdef DEC_EX_PIPE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    // Saturating counters; FlushE deliberately does not clear them.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (ValidD && !ready_q && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (!out_v_q && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q  <= 32'd0;
            bubble_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign StallCnt  = stall_cnt_q;
    assign BubbleCnt = bubble_cnt_q;
`else
    assign StallCnt  = 32'd0;
    assign BubbleCnt = 32'd0;
`endif

endmodule

// File: tb/tb_dec_ex_pipe.sv
// Scoreboard bench for dec_ex_pipe: each accepted PC is queued and compared when it reaches Execute.
module tb_dec_ex_pipe;

    logic        clk;
    logic        rst;
    logic        ValidD, ReadyD, FlushE, ReadyE, ValidE;
    logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ExtImmD;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic [6:0]  opcodeD;
    logic [2:0]  funct3D;
    logic [15:0] CtrlD;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ExtImmE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [6:0]  opcodeE;
    logic [2:0]  funct3E;
    logic [15:0] CtrlE;
    logic [31:0] StallCnt, BubbleCnt;

    int          vectors_applied = 0;
    int          miscompares = 0;
    logic [31:0] sb_q[$];
    logic [31:0] m_stall = 32'd0;
    logic [31:0] m_bubble = 32'd0;

    dec_ex_pipe dut (
        .clk(clk), .rst(rst), .ValidD(ValidD), .ReadyD(ReadyD),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ExtImmD(ExtImmD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .opcodeD(opcodeD), .funct3D(funct3D), .CtrlD(CtrlD),
        .FlushE(FlushE), .ReadyE(ReadyE), .ValidE(ValidE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ExtImmE(ExtImmE),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .opcodeE(opcodeE), .funct3E(funct3E), .CtrlE(CtrlE),
        .StallCnt(StallCnt), .BubbleCnt(BubbleCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors_applied++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Payload fields are derived from the PC so a single queued value identifies the whole instruction.
    function automatic logic [31:0] f_misc(input logic [31:0] pc);
        logic [4:0] rs1, rs2, rd;
        rs1 = pc[6:2];
        rs2 = pc[7:3];
        rd  = pc[6:2] ^ 5'h1F;
        return {7'd0, rs1, rs2, rd, pc[4:0], 2'b11, pc[4:2]};
    endfunction

    task automatic step(input logic v, input logic [31:0] pc, input logic re,
                        input logic fl, input logic rs);
        logic [31:0] e;
        logic        vld, acc, con;
        ValidD   = v;
        PCD      = pc;
        RD1D     = pc ^ 32'h5A5A_0000;
        RD2D     = ~pc;
        PCPlus4D = pc + 32'd4;
        ExtImmD  = pc << 1;
        Rs1D     = pc[6:2];
        Rs2D     = pc[7:3];
        RdD      = pc[6:2] ^ 5'h1F;
        opcodeD  = {pc[4:0], 2'b11};
        funct3D  = pc[4:2];
        CtrlD    = {pc[15:1], 1'b1};
        ReadyE   = re;
        FlushE   = fl;
        rst      = rs;
        @(negedge clk);
        vld = (sb_q.size() != 0);
        e   = vld ? sb_q[0] : 32'd0;
        check("ValidE", {31'd0, ValidE}, {31'd0, vld});
        check("ReadyD", {31'd0, ReadyD}, {31'd0, (sb_q.size() < 2)});
        check("PCE", PCE, e);
        check("RD1E", RD1E, vld ? (e ^ 32'h5A5A_0000) : 32'd0);
        check("RD2E", RD2E, vld ? ~e : 32'd0);
        check("PCPlus4E", PCPlus4E, vld ? (e + 32'd4) : 32'd0);
        check("ExtImmE", ExtImmE, vld ? (e << 1) : 32'd0);
        check("FieldsE", {7'd0, Rs1E, Rs2E, RdE, opcodeE, funct3E}, vld ? f_misc(e) : 32'd0);
        check("CtrlE", {16'd0, CtrlE}, vld ? {16'd0, e[15:1], 1'b1} : 32'd0);
        if (!rs) begin
            sb_q.delete();
            m_stall  = 32'd0;
            m_bubble = 32'd0;
        end else begin
            if (v && sb_q.size() == 2 && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            if (!vld && m_bubble != 32'hFFFF_FFFF) m_bubble = m_bubble + 32'd1;
            acc = v && (sb_q.size() < 2);
            con = vld && re;
            if (fl) begin
                sb_q.delete();
            end else begin
                if (con) void'(sb_q.pop_front());
                if (acc) sb_q.push_back(pc);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
`ifdef DEC_EX_PIPE_PERF_EN
        check({tag, "_stall"}, StallCnt, m_stall);
        check({tag, "_bubble"}, BubbleCnt, m_bubble);
`else
        check({tag, "_stall"}, StallCnt, 32'd0);
        check({tag, "_bubble"}, BubbleCnt, 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] pc;
        rst = 1'b0; ValidD = 1'b0; FlushE = 1'b0; ReadyE = 1'b0;
        PCD = 32'd0; RD1D = 32'd0; RD2D = 32'd0; PCPlus4D = 32'd0; ExtImmD = 32'd0;
        Rs1D = 5'd0; Rs2D = 5'd0; RdD = 5'd0; opcodeD = 7'd0; funct3D = 3'd0; CtrlD = 16'd0;
        @(posedge clk);
        #1;

        // Reset, then streaming at full throughput.
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
        check_counters("reset");
        step(1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h4, 1'b1, 1'b0, 1'b1);
        step(1'b1, 32'h8, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // Backpressure: two entries fill, then three stalled offers of 0x18.
        step(1'b1, 32'h10, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h14, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h18, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        check_counters("perf");

        // Flush with both entries full and a new input offered.
        step(1'b1, 32'h20, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h24, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h28, 1'b0, 1'b1, 1'b1);
        step(1'b1, 32'h2C, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // Reset mid-operation with both entries full.
        step(1'b1, 32'h30, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h34, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h38, 1'b1, 1'b1, 1'b0);
        step(1'b1, 32'h3C, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        check_counters("midreset");

        // Random traffic with occasional flushes.
        pc = 32'h1000;
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 3) != 0), pc, ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 19) == 0), 1'b1);
            pc = pc + 32'd4;
        end
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        check_counters("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
